// File: rtl/hazard3_regfile_dbg_arb.sv
// Clears the Hazard3 register file after reset, then arbitrates its ports between the core
// pipeline and the debug module's abstract register accesses (granted only while halted).
module hazard3_regfile_dbg_arb #(
  parameter int N_REGS = 16,
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_halted,
  input  logic [W_ADDR-1:0] core_raddr1,
  input  logic [W_ADDR-1:0] core_raddr2,
  input  logic [W_ADDR-1:0] core_waddr,
  input  logic [W_DATA-1:0] core_wdata,
  input  logic              core_wen,
  output logic              rf_busy,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_write,
  input  logic [W_ADDR-1:0] dbg_req_addr,
  input  logic [W_DATA-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [W_DATA-1:0] dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  output logic [W_ADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  output logic              rf_wen,
  input  logic [W_DATA-1:0] rf_rdata1
);

  localparam int W_CNT = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(N_REGS - 1);

  typedef enum logic [2:0] {INIT, IDLE, EXEC, RD_WAIT, RSP} state_t;

  state_t            state;
  logic [W_CNT-1:0]  cnt;
  logic              req_write;
  logic [W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0] req_wdata;
  logic              req_fire;
  logic              req_oob;

  assign dbg_req_ready = (state == IDLE) && core_halted && !rst;
  assign req_fire      = dbg_req_valid && dbg_req_ready;
  assign req_oob       = 32'(dbg_req_addr) >= N_REGS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      cnt           <= '0;
      req_write     <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_rdata <= '0;
      dbg_rsp_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (req_fire) begin
            req_write <= dbg_req_write;
            req_addr  <= dbg_req_addr;
            req_wdata <= dbg_req_wdata;
            if (req_oob) begin
              dbg_rsp_err   <= 1'b1;
              dbg_rsp_valid <= 1'b1;
              state         <= RSP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (req_write) begin
            dbg_rsp_valid <= 1'b1;
            state         <= RSP;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // x0 reads as zero regardless of what the regfile array holds
          dbg_rsp_rdata <= (req_addr == '0) ? '0 : rf_rdata1;
          dbg_rsp_valid <= 1'b1;
          state         <= RSP;
        end
        RSP: begin
          if (dbg_rsp_ready) begin
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_rdata <= '0;
            dbg_rsp_err   <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // While rst is held the ports already look like the first clear cycle
  always_comb begin
    rf_raddr1 = core_raddr1;
    rf_raddr2 = core_raddr2;
    rf_waddr  = core_waddr;
    rf_wdata  = core_wdata;
    rf_wen    = 1'b0;
    rf_busy   = 1'b1;
    if (rst) begin
      rf_waddr = '0;
      rf_wdata = '0;
      rf_wen   = 1'b1;
    end else begin
      case (state)
        INIT: begin
          rf_waddr = W_ADDR'(cnt);
          rf_wdata = '0;
          rf_wen   = 1'b1;
        end
        IDLE: begin
          rf_wen  = core_wen;
          rf_busy = 1'b0;
        end
        EXEC: begin
          if (req_write) begin
            rf_waddr = req_addr;
            rf_wdata = req_wdata;
            rf_wen   = (req_addr != '0);
          end else begin
            rf_raddr1 = req_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_regfile_dbg_arb.sv
// Bench for hazard3_regfile_dbg_arb: a registered-read regfile stands in for the array and a
// flat register-value model predicts every debug response, error flag and response latency.
module tb_hazard3_regfile_dbg_arb;

  localparam int N_REGS = 16;
  localparam int W_DATA = 32;
  localparam int W_ADDR = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_halted;
  logic [W_ADDR-1:0] core_raddr1, core_raddr2, core_waddr;
  logic [W_DATA-1:0] core_wdata;
  logic              core_wen;
  logic              rf_busy;
  logic              dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [W_ADDR-1:0] dbg_req_addr;
  logic [W_DATA-1:0] dbg_req_wdata;
  logic              dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
  logic [W_DATA-1:0] dbg_rsp_rdata;
  logic [W_ADDR-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [W_DATA-1:0] rf_wdata, rf_rdata1;
  logic              rf_wen;

  int checks = 0;
  int errors = 0;
  logic [W_DATA-1:0] model [0:N_REGS-1];
  logic [W_DATA-1:0] rfMem [0:(1<<W_ADDR)-1];
  logic monitorZero = 1'b0;
  int   zeroWriteCnt = 0;
  int   zeroBefore;
  logic rndWr, rndCollide;
  logic [W_ADDR-1:0] rndAddr;
  logic [W_DATA-1:0] rndData;
  int   rndHold;

  hazard3_regfile_dbg_arb #(.N_REGS(N_REGS), .W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst), .core_halted(core_halted),
    .core_raddr1(core_raddr1), .core_raddr2(core_raddr2), .core_waddr(core_waddr),
    .core_wdata(core_wdata), .core_wen(core_wen), .rf_busy(rf_busy),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_write(dbg_req_write),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_wen(rf_wen), .rf_rdata1(rf_rdata1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wen) rfMem[rf_waddr] <= rf_wdata;
    rf_rdata1 <= rfMem[rf_raddr1];
  end

  always @(negedge clk) begin
    if (monitorZero && rf_wen && rf_waddr == '0) zeroWriteCnt <= zeroWriteCnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Resets mid-anything, checks the reset-cycle outputs, then times and checks the clear sweep
  task automatic runReset();
    int busyCnt;
    int seqErr;
    rst = 1'b1;
    dbg_req_valid = 1'b0;
    dbg_rsp_ready = 1'b0;
    core_wen = 1'b1;
    core_waddr = 5'd9;
    core_wdata = 32'hBAD0BAD0;
    @(negedge clk); #1;
    checkOutput("rst_rf_wen", rf_wen, 1);
    checkOutput("rst_rf_waddr", rf_waddr, 0);
    checkOutput("rst_rf_wdata", rf_wdata, 0);
    checkOutput("rst_rf_busy", rf_busy, 1);
    checkOutput("rst_req_ready", dbg_req_ready, 0);
    checkOutput("rst_rsp_valid", dbg_rsp_valid, 0);
    checkOutput("rst_rsp_rdata", dbg_rsp_rdata, 0);
    checkOutput("rst_rsp_err", dbg_rsp_err, 0);
    @(negedge clk);
    rst = 1'b0;
    busyCnt = 0;
    seqErr = 0;
    #1;
    while (rf_busy && busyCnt < 100) begin
      if (rf_wen !== 1'b1 || rf_waddr !== W_ADDR'(busyCnt) || rf_wdata !== '0) seqErr++;
      busyCnt++;
      @(negedge clk); #1;
    end
    core_wen = 1'b0;
    checkOutput("init_busy_cycles", busyCnt, N_REGS);
    checkOutput("init_sweep", seqErr, 0);
    for (int i = 0; i < N_REGS; i++) model[i] = '0;
  endtask

  task automatic dbgTransact(input logic wr, input logic [W_ADDR-1:0] addr, input logic [W_DATA-1:0] wd,
                             input int hold, input logic dropHalt, input logic collide,
                             output logic [W_DATA-1:0] rd, output logic er,
                             output int acceptWait, output int lat);
    logic stable;
    dbg_req_valid = 1'b1;
    dbg_req_write = wr;
    dbg_req_addr  = addr;
    dbg_req_wdata = wd;
    #1;
    acceptWait = 0;
    while (!dbg_req_ready && acceptWait < 50) begin
      @(negedge clk); #1;
      acceptWait++;
    end
    checkOutput("req_accept", dbg_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    dbg_req_addr  = W_ADDR'($urandom);
    dbg_req_wdata = $urandom;
    if (dropHalt) core_halted = 1'b0;
    if (collide) begin
      core_wen   = 1'b1;
      core_waddr = 5'd9;
      core_wdata = $urandom;
    end
    #1;
    lat = 1;
    while (!dbg_rsp_valid && lat < 50) begin
      @(negedge clk); #1;
      lat++;
    end
    checkOutput("rsp_arrives", dbg_rsp_valid, 1);
    rd = dbg_rsp_rdata;
    er = dbg_rsp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== rd || dbg_rsp_err !== er) stable = 1'b0;
    end
    if (hold > 0) checkOutput("rsp_stable", stable, 1);
    core_wen = 1'b0;
    dbg_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dbg_rsp_ready = 1'b0;
  endtask

  // One debug transaction checked against the register-value model; expWait < 0 skips that check
  task automatic applyStimulus(input string tag, input logic wr, input logic [W_ADDR-1:0] addr,
                               input logic [W_DATA-1:0] wd, input int hold, input logic dropHalt,
                               input logic collide, input int expWait);
    logic [W_DATA-1:0] rd, expRd;
    logic er, oob;
    int acceptWait, lat, expLat;
    oob    = int'(addr) >= N_REGS;
    expRd  = (!wr && !oob) ? model[addr[3:0]] : '0;
    expLat = oob ? 1 : (wr ? 2 : 3);
    dbgTransact(wr, addr, wd, hold, dropHalt, collide, rd, er, acceptWait, lat);
    checkOutput({tag, "_rdata"}, rd, expRd);
    checkOutput({tag, "_err"}, er, oob);
    checkOutput({tag, "_latency"}, lat, expLat);
    if (expWait >= 0) checkOutput({tag, "_accept_wait"}, acceptWait, expWait);
    if (wr && !oob && addr != '0) model[addr[3:0]] = wd;
  endtask

  initial begin
    rst = 1'b1;
    core_halted = 1'b0;
    core_raddr1 = '0;
    core_raddr2 = '0;
    core_waddr = '0;
    core_wdata = '0;
    core_wen = 1'b0;
    dbg_req_valid = 1'b0;
    dbg_req_write = 1'b0;
    dbg_req_addr = '0;
    dbg_req_wdata = '0;
    dbg_rsp_ready = 1'b0;

    runReset();
    core_halted = 1'b1;
    for (int i = 0; i < N_REGS; i++) applyStimulus("init_read", 1'b0, W_ADDR'(i), '0, 0, 1'b0, 1'b0, 0);

    applyStimulus("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0);
    applyStimulus("rd5", 1'b0, 5'd5, '0, 0, 1'b0, 1'b0, 0);
    applyStimulus("rd20", 1'b0, 5'd20, '0, 0, 1'b0, 1'b0, 0);

    zeroBefore = zeroWriteCnt;
    monitorZero = 1'b1;
    applyStimulus("wr0", 1'b1, 5'd0, 32'h00001234, 0, 1'b0, 1'b0, 0);
    applyStimulus("rd0", 1'b0, 5'd0, '0, 0, 1'b0, 1'b0, 0);
    monitorZero = 1'b0;
    checkOutput("x0_never_written", zeroWriteCnt - zeroBefore, 0);

    // Core keeps the ports while running; the pending request waits for halt
    core_halted = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b1;
    dbg_req_addr = 5'd2;
    dbg_req_wdata = 32'h22222222;
    core_wen = 1'b1;
    core_waddr = 5'd7;
    core_wdata = 32'h77777777;
    core_raddr1 = 5'd11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("gate_ready", dbg_req_ready, 0);
      checkOutput("gate_busy", rf_busy, 0);
      checkOutput("gate_wen", rf_wen, 1);
      checkOutput("gate_waddr", rf_waddr, 7);
      checkOutput("gate_raddr1", rf_raddr1, 11);
    end
    core_wen = 1'b0;
    model[7] = 32'h77777777;
    core_halted = 1'b1;
    #1;
    checkOutput("halt_ready_same_cycle", dbg_req_ready, 1);
    applyStimulus("wr2", 1'b1, 5'd2, 32'h22222222, 0, 1'b0, 1'b0, 0);
    applyStimulus("rd7", 1'b0, 5'd7, '0, 0, 1'b0, 1'b0, 0);

    applyStimulus("wr3_halt_drop", 1'b1, 5'd3, 32'h0000A5A5, 0, 1'b1, 1'b1, 0);
    core_halted = 1'b1;
    applyStimulus("rd3", 1'b0, 5'd3, '0, 0, 1'b0, 1'b0, 0);
    applyStimulus("rd5_backpressure", 1'b0, 5'd5, '0, 5, 1'b0, 1'b1, 0);
    applyStimulus("rd9", 1'b0, 5'd9, '0, 0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      rndWr = 1'($urandom_range(0, 1));
      rndAddr = W_ADDR'($urandom_range(0, 23));
      rndData = $urandom;
      rndHold = $urandom_range(0, 2);
      rndCollide = 1'($urandom_range(0, 1));
      applyStimulus("rand", rndWr, rndAddr, rndData, rndHold, 1'b0, rndCollide, 0);
    end

    // Reset lands while the read sits in RD_WAIT
    applyStimulus("wr4", 1'b1, 5'd4, 32'hCAFEF00D, 0, 1'b0, 1'b0, 0);
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b0;
    dbg_req_addr = 5'd4;
    #1;
    checkOutput("midrd_accept", dbg_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    @(negedge clk);
    runReset();
    applyStimulus("rd4_after_reset", 1'b0, 5'd4, '0, 0, 1'b0, 1'b0, 0);
    applyStimulus("rd5_after_reset", 1'b0, 5'd5, '0, 0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
